fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arb_pkg.sv | 16 +
 rtl/fb_arbiter.sv | 113 +++++++++++
 tb/tb_fb_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and default sizing for the framebuffer arbiter.
package fb_arb_pkg;

  localparam int unsigned DefaultAw        = 18;
  localparam int unsigned DefaultDw        = 16;
  localparam int unsigned DefaultBurstLen  = 8;
  localparam int unsigned DefaultStarveMax = 16;
  localparam int unsigned DefaultMaxOut    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StDisp,
    StWr
  } arb_state_e;

endpackage

// File: rtl/fb_arbiter.sv
// Two-master framebuffer arbiter: display prefetch reads in bursts, pixel writes with an
// anti-starvation override. Grants are combinational so commands see no added latency.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned AW         = DefaultAw,
  parameter int unsigned DW         = DefaultDw,
  parameter int unsigned BURST_LEN  = DefaultBurstLen,
  parameter int unsigned STARVE_MAX = DefaultStarveMax,
  parameter int unsigned MAX_OUT    = DefaultMaxOut
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q;
  logic [SW-1:0] wait_q;
  logic [BW-1:0] burst_q;
  logic [OW-1:0] out_q;
  logic          starve;
  logic          accept;

  assign starve = (wait_q == SW'(STARVE_MAX));

  // mem_valid is a function of state and requester inputs only, never of mem_ready.
  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = disp_addr;
    case (state_q)
      StDisp: mem_valid = disp_req && (out_q < OW'(MAX_OUT));
      StWr: begin
        mem_valid = wr_req;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
      end
      default: ;
    endcase
    if (RST) mem_valid = 1'b0;
  end

  assign mem_wdata   = wr_data;
  assign accept      = mem_valid && mem_ready;
  assign disp_gnt    = accept && !mem_we;
  assign wr_gnt      = accept && mem_we;
  assign disp_rvalid = mem_rvalid;
  assign disp_rdata  = mem_rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      wait_q  <= '0;
      burst_q <= '0;
      out_q   <= '0;
    end else begin
      if (!wr_req || wr_gnt) begin
        wait_q <= '0;
      end else if (!starve) begin
        wait_q <= wait_q + 1'b1;
      end

      // Returns after a reset may outnumber tracked reads, so never decrement past zero.
      if (disp_gnt && !mem_rvalid) begin
        out_q <= out_q + 1'b1;
      end else if (!disp_gnt && mem_rvalid && (out_q != '0)) begin
        out_q <= out_q - 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (wr_req && (out_q == '0) && (starve || !disp_req)) begin
            state_q <= StWr;
          end else if (disp_req && !starve) begin
            state_q <= StDisp;
            burst_q <= '0;
          end
        end
        StDisp: begin
          if (disp_gnt) burst_q <= burst_q + 1'b1;
          if (!disp_req ||
              (disp_gnt && ((burst_q == BW'(BURST_LEN - 1)) || starve))) begin
            state_q <= StIdle;
          end
        end
        StWr: begin
          if (wr_gnt || !wr_req) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus a randomized protocol run.
module tb_fb_arbiter;
  import fb_arb_pkg::*;

  localparam int unsigned AW         = 18;
  localparam int unsigned DW         = 16;
  localparam int unsigned BURST_LEN  = 8;
  localparam int unsigned STARVE_MAX = 16;
  localparam int unsigned MAX_OUT    = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;

  fb_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .BURST_LEN (BURST_LEN),
    .STARVE_MAX(STARVE_MAX),
    .MAX_OUT   (MAX_OUT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_gnt   (disp_gnt),
    .disp_rvalid(disp_rvalid),
    .disp_rdata (disp_rdata),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  int lat = 2;
  bit ret_en = 1'b1;
  int ret_q[$];       // due cycle of each accepted read, in issue order
  int outstanding = 0; // reads the arbiter should still be tracking
  bit rd_acc;

  // Memory model: accepted reads return in order, lat cycles later, while ret_en is set.
  always @(posedge CLK) begin
    #1;
    cyc++;
    mem_rdata  = DW'($urandom);
    mem_rvalid = 1'b0;
    if (ret_en && ret_q.size() > 0 && ret_q[0] <= cyc) begin
      void'(ret_q.pop_front());
      mem_rvalid = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      outstanding = 0;
    end else begin
      rd_acc = mem_valid && mem_ready && !mem_we;
      if (rd_acc) ret_q.push_back(cyc + lat);
      if (rd_acc && !mem_rvalid) outstanding++;
      else if (!rd_acc && mem_rvalid && outstanding > 0) outstanding--;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic drain();
    int t = 0;
    disp_req = 1'b0;
    wr_req   = 1'b0;
    ret_en   = 1'b1;
    mem_ready = 1'b1;
    while (ret_q.size() > 0 && t < 200) begin
      tick();
      t++;
    end
    n_checks++;
    if (t >= 200) $display("FAIL drain_timeout pending=%0d want 0", ret_q.size());
    else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    mem_ready = 1'b1;
    repeat (2) tick();
    disp_req = 1'b1;
    wr_req   = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got %b want 0", mem_valid);
    else n_pass++;
    n_checks++;
    if (disp_gnt !== 1'b0) $display("FAIL reset_disp_gnt got %b want 0", disp_gnt);
    else n_pass++;
    n_checks++;
    if (wr_gnt !== 1'b0) $display("FAIL reset_wr_gnt got %b want 0", wr_gnt);
    else n_pass++;
    tick();
    RST = 1'b0;
    disp_req = 1'b0;
    wr_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      n_checks++;
      if (mem_valid !== 1'b0) $display("FAIL idle_after_reset cyc%0d got %b want 0", k, mem_valid);
      else n_pass++;
      tick();
    end
  endtask

  // Held display request: 8 grants, one IDLE cycle, repeat.
  task automatic test_burst();
    bit g;
    lat = 2;
    ret_en = 1'b1;
    mem_ready = 1'b1;
    disp_req = 1'b1;
    disp_addr = AW'($urandom);
    for (int k = 0; k < 27; k++) begin
      @(negedge CLK);
      n_checks++;
      if (disp_gnt !== (k % 9 != 0))
        $display("FAIL burst_gnt cyc%0d got %b want %b", k, disp_gnt, (k % 9 != 0));
      else n_pass++;
      if (disp_gnt) begin
        n_checks++;
        if (mem_addr !== disp_addr || mem_we !== 1'b0)
          $display("FAIL burst_cmd addr got %0h want %0h we got %b want 0", mem_addr, disp_addr,
                   mem_we);
        else n_pass++;
      end
      g = disp_gnt;
      tick();
      if (g) disp_addr = AW'($urandom);
    end
    drain();
  endtask

  task automatic test_starve();
    int first_wr = -1;
    int resume = -1;
    // Starved read at cycle STARVE_MAX returns lat cycles later; one more cycle to leave IDLE.
    int exp_wr = int'(STARVE_MAX) + lat + 2;
    bit g, w;
    lat = 2;
    mem_ready = 1'b1;
    disp_req = 1'b1;
    disp_addr = AW'($urandom);
    wr_req = 1'b1;
    wr_addr = AW'($urandom);
    wr_data = DW'($urandom);
    for (int k = 0; k < 60 && resume < 0; k++) begin
      @(negedge CLK);
      if (wr_gnt && first_wr < 0) begin
        first_wr = k;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== wr_addr || mem_wdata !== wr_data)
          $display("FAIL starve_wr_cmd we=%b addr got %0h want %0h data got %0h want %0h",
                   mem_we, mem_addr, wr_addr, mem_wdata, wr_data);
        else n_pass++;
      end
      if (first_wr >= 0 && k > first_wr && disp_gnt) resume = k;
      g = disp_gnt;
      w = wr_gnt;
      tick();
      if (g) disp_addr = AW'($urandom);
      if (w) wr_req = 1'b0;
    end
    n_checks++;
    if (first_wr != exp_wr) $display("FAIL starve_wr_cycle got %0d want %0d", first_wr, exp_wr);
    else n_pass++;
    n_checks++;
    if (first_wr < 0 || first_wr > int'(STARVE_MAX + BURST_LEN + MAX_OUT) + lat + 2)
      $display("FAIL starve_wr_bound got %0d want <= %0d", first_wr,
               int'(STARVE_MAX + BURST_LEN + MAX_OUT) + lat + 2);
    else n_pass++;
    n_checks++;
    if (resume < 0 || resume > first_wr + 3)
      $display("FAIL starve_disp_resume got %0d want <= %0d", resume, first_wr + 3);
    else n_pass++;
    drain();
  endtask

  task automatic test_maxout();
    int cnt = 0;
    bit seen = 1'b0;
    bit g;
    ret_en = 1'b0;
    mem_ready = 1'b1;
    disp_req = 1'b1;
    disp_addr = AW'($urandom);
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (disp_gnt) cnt++;
      if (k >= 20) begin
        n_checks++;
        if (mem_valid !== 1'b0) $display("FAIL maxout_stall cyc%0d got %b want 0", k, mem_valid);
        else n_pass++;
      end
      g = disp_gnt;
      tick();
      if (g) disp_addr = AW'($urandom);
    end
    n_checks++;
    if (cnt != int'(MAX_OUT)) $display("FAIL maxout_gnts got %0d want %0d", cnt, MAX_OUT);
    else n_pass++;
    ret_en = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (disp_gnt) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (!seen) $display("FAIL maxout_resume got 0 want 1");
    else n_pass++;
    drain();
  endtask

  task automatic test_wr_outstanding();
    int cnt = 0;
    int t = 0;
    bit seen = 1'b0;
    bit g;
    ret_en = 1'b0;
    mem_ready = 1'b1;
    disp_req = 1'b1;
    disp_addr = AW'($urandom);
    while (cnt < 3 && t < 20) begin
      @(negedge CLK);
      g = disp_gnt;
      if (g) cnt++;
      t++;
      tick();
      if (cnt == 3) disp_req = 1'b0;
      else if (g) disp_addr = AW'($urandom);
    end
    n_checks++;
    if (cnt != 3) $display("FAIL wrout_reads got %0d want 3", cnt);
    else n_pass++;
    wr_req = 1'b1;
    wr_addr = AW'($urandom);
    wr_data = DW'($urandom);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      n_checks++;
      if (wr_gnt !== 1'b0 || mem_valid !== 1'b0)
        $display("FAIL wrout_blocked cyc%0d gnt got %b valid got %b want 0", k, wr_gnt, mem_valid);
      else n_pass++;
      tick();
    end
    ret_en = 1'b1;
    for (int k = 0; k < 15 && !seen; k++) begin
      @(negedge CLK);
      if (wr_gnt) begin
        seen = 1'b1;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== wr_addr || mem_wdata !== wr_data || outstanding != 0)
          $display("FAIL wrout_cmd we=%b addr got %0h want %0h data got %0h want %0h out=%0d",
                   mem_we, mem_addr, wr_addr, mem_wdata, wr_data, outstanding);
        else n_pass++;
      end
      tick();
      if (seen) wr_req = 1'b0;
    end
    n_checks++;
    if (!seen) $display("FAIL wrout_gnt got 0 want 1");
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_midburst();
    int cnt = 0;
    int t = 0;
    int rv = 0;
    bit g;
    ret_en = 1'b0;
    mem_ready = 1'b1;
    disp_req = 1'b1;
    disp_addr = AW'($urandom);
    while (cnt < 5 && t < 20) begin
      @(negedge CLK);
      g = disp_gnt;
      if (g) cnt++;
      t++;
      tick();
      if (g) disp_addr = AW'($urandom);
    end
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (mem_valid !== 1'b0 || disp_gnt !== 1'b0)
      $display("FAIL rstmid_during valid got %b gnt got %b want 0", mem_valid, disp_gnt);
    else n_pass++;
    tick();
    RST = 1'b0;
    disp_req = 1'b0;
    ret_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      n_checks++;
      if (mem_valid !== 1'b0 || disp_rvalid !== mem_rvalid)
        $display("FAIL rstmid_after cyc%0d valid got %b want 0 rvalid got %b want %b", k,
                 mem_valid, disp_rvalid, mem_rvalid);
      else n_pass++;
      if (mem_rvalid) rv++;
      tick();
    end
    n_checks++;
    if (rv != 5) $display("FAIL rstmid_late_returns got %0d want 5", rv);
    else n_pass++;
    // A clean zero count admits exactly MAX_OUT new reads with returns withheld.
    ret_en = 1'b0;
    disp_req = 1'b1;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      g = disp_gnt;
      if (g) cnt++;
      tick();
      if (g) disp_addr = AW'($urandom);
    end
    n_checks++;
    if (cnt != int'(MAX_OUT)) $display("FAIL rstmid_outcnt gnts got %0d want %0d", cnt, MAX_OUT);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    bit held = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_data = '0;
    logic h_we = 1'b0;
    int acc_rd = 0, acc_wr = 0, n_dg = 0, n_wg = 0;
    bit dg = 1'b0, wg = 1'b0;
    ret_en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      mem_ready = ($urandom_range(0, 1) == 1);
      lat = int'($urandom_range(1, 4));
      if (!disp_req || dg) begin
        disp_req = ($urandom_range(0, 3) != 0);
        disp_addr = AW'($urandom);
      end
      if (!wr_req || wg) begin
        wr_req = ($urandom_range(0, 2) == 0);
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
      end
      @(negedge CLK);
      if (held) begin
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== h_addr || mem_we !== h_we ||
            (h_we && mem_wdata !== h_data))
          $display("FAIL rand_stable cyc%0d valid=%b addr got %0h want %0h we got %b want %b",
                   k, mem_valid, mem_addr, h_addr, mem_we, h_we);
        else n_pass++;
      end
      n_checks++;
      if (disp_gnt !== (mem_valid && mem_ready && !mem_we) ||
          wr_gnt !== (mem_valid && mem_ready && mem_we) ||
          (disp_gnt && mem_addr !== disp_addr) ||
          (wr_gnt && (mem_addr !== wr_addr || mem_wdata !== wr_data)))
        $display("FAIL rand_gnt cyc%0d dgnt=%b wgnt=%b valid=%b ready=%b we=%b", k, disp_gnt,
                 wr_gnt, mem_valid, mem_ready, mem_we);
      else n_pass++;
      n_checks++;
      if (disp_rvalid !== mem_rvalid || (mem_rvalid && disp_rdata !== mem_rdata))
        $display("FAIL rand_rdata cyc%0d got %b/%0h want %b/%0h", k, disp_rvalid, disp_rdata,
                 mem_rvalid, mem_rdata);
      else n_pass++;
      n_checks++;
      if (outstanding > int'(MAX_OUT))
        $display("FAIL rand_outstanding cyc%0d got %0d want <= %0d", k, outstanding, MAX_OUT);
      else n_pass++;
      if (mem_valid && mem_ready) begin
        if (mem_we) acc_wr++;
        else acc_rd++;
      end
      dg = disp_gnt;
      wg = wr_gnt;
      if (dg) n_dg++;
      if (wg) n_wg++;
      held = mem_valid && !mem_ready;
      h_addr = mem_addr;
      h_data = mem_wdata;
      h_we = mem_we;
    end
    n_checks++;
    if (n_dg != acc_rd) $display("FAIL rand_disp_count got %0d want %0d", n_dg, acc_rd);
    else n_pass++;
    n_checks++;
    if (n_wg != acc_wr) $display("FAIL rand_wr_count got %0d want %0d", n_wg, acc_wr);
    else n_pass++;
    drain();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_starve();
    test_maxout();
    test_wr_outstanding();
    test_reset_midburst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
